// File: rtl/du_pkg.sv
// Shared definitions for the debug-unit host link: data widths, command bytes
// understood by debug_unit, and the host-side FSM state encoding.
package du_pkg;

  localparam int BYTE           = 8;
  localparam int DWORD          = 32;
  localparam int BYTES_PER_WORD = DWORD / BYTE;

  // Command bytes; must stay in step with the decoder inside debug_unit.
  localparam logic [BYTE-1:0] CMD_NOP       = 8'h00;
  localparam logic [BYTE-1:0] CMD_READ_PC   = 8'h01;
  localparam logic [BYTE-1:0] CMD_READ_REGS = 8'h02;
  localparam logic [BYTE-1:0] CMD_READ_MEM  = 8'h03;
  localparam logic [BYTE-1:0] CMD_STEP      = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_RECV,
    ST_FIN
  } host_state_t;

endpackage

// File: rtl/du_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words, strobing each full word
// and flushing a trailing partial word zero-padded on request.
module du_byte_packer
  import du_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [BYTE-1:0]  shift_data,
  input  logic             flush,
  output logic [DWORD-1:0] word,
  output logic             word_valid,
  output logic [IDX_W-1:0] word_idx
);

  logic [DWORD-1:0] acc_q;
  logic [DWORD-1:0] acc_next;
  logic [1:0]       lane_q;
  logic [IDX_W-1:0] word_cnt_q;
  logic             emit;

  // A flush with no bytes pending (and none arriving) emits nothing.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (shift_en && (lane_q == i[1:0])) begin
        acc_next[i*BYTE +: BYTE] = shift_data;
      end
    end
    emit = (shift_en && (lane_q == 2'd3)) ||
           (flush && (shift_en || (lane_q != 2'd0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      lane_q     <= '0;
      word_cnt_q <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
    end else begin
      word_valid <= emit;
      if (clear) begin
        acc_q      <= '0;
        lane_q     <= '0;
        word_cnt_q <= '0;
      end else if (emit) begin
        word       <= acc_next;
        word_idx   <= word_cnt_q;
        word_cnt_q <= word_cnt_q + IDX_W'(1);
        acc_q      <= '0;
        lane_q     <= '0;
      end else if (shift_en) begin
        acc_q  <= acc_next;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/du_host_link.sv
// Host side of the debug-unit link: sends one command byte over the UART and
// collects the fixed-length reply as 32-bit words, aborting on rx silence.
module du_host_link
  import du_pkg::*;
#(
  parameter int LEN_W     = 10,
  parameter int TO_W      = 20,
  parameter int TO_CYCLES = 1000000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [BYTE-1:0]  i_cmd,
  input  logic [LEN_W-1:0] i_rsp_len,
  input  logic             i_cmd_valid,
  output logic             o_busy,
  output logic [BYTE-1:0]  o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  input  logic [BYTE-1:0]  i_rx_data,
  input  logic             i_rx_done,
  output logic [DWORD-1:0] o_word,
  output logic             o_word_valid,
  output logic [LEN_W-3:0] o_word_idx,
  output logic             o_done,
  output logic             o_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  host_state_t      state_q;
  host_state_t      state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_after;
  logic [TO_W-1:0]  to_cnt_q;
  logic             accept;
  logic             capture;
  logic             to_hit;
  logic             flush;

  // Bytes are taken from WAIT_TX onward, but never past the requested length.
  assign accept      = (state_q == ST_IDLE) && i_cmd_valid;
  assign capture     = i_rx_done && ((state_q == ST_WAIT_TX) || (state_q == ST_RECV)) &&
                       (count_q != len_q);
  assign count_after = capture ? (count_q + LEN_W'(1)) : count_q;
  assign to_hit      = (state_q == ST_RECV) && !i_rx_done && (to_cnt_q == TO_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_next = (count_after == len_q) ? ST_FIN : ST_RECV;
        end
      end
      ST_RECV: begin
        if (capture && (count_after == len_q)) begin
          state_next = ST_FIN;
        end else if (to_hit) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Flush rides on the cycle that leaves for FIN, so the last word lines up with o_done.
  always_comb begin
    o_busy     = (state_q != ST_IDLE);
    o_tx_start = (state_q == ST_SEND);
    o_done     = (state_q == ST_FIN);
    flush      = ((state_q == ST_WAIT_TX) || (state_q == ST_RECV)) && (state_next == ST_FIN);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      len_q     <= '0;
      count_q   <= '0;
      to_cnt_q  <= '0;
      o_tx_data <= '0;
      o_timeout <= 1'b0;
    end else if (accept) begin
      len_q     <= i_rsp_len;
      count_q   <= '0;
      to_cnt_q  <= '0;
      o_tx_data <= i_cmd;
      o_timeout <= 1'b0;
    end else begin
      count_q <= count_after;
      if (capture) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_RECV) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (to_hit) begin
        o_timeout <= 1'b1;
      end
    end
  end

  du_byte_packer #(
    .IDX_W(LEN_W - 2)
  ) u_packer (
    .clk       (i_clock),
    .rst       (i_reset),
    .clear     (accept),
    .shift_en  (capture),
    .shift_data(i_rx_data),
    .flush     (flush),
    .word      (o_word),
    .word_valid(o_word_valid),
    .word_idx  (o_word_idx)
  );

endmodule
